// File: rtl/frame_tx.sv
// frame_tx: raster frame reader. Walks a frame_h x frame_w pixel memory in
// raster order, optionally pausing (hold) and idling row_gap cycles between
// rows, and streams the returned pixels out with start/valid/done strobes.
// Ports:
//   clk, reset          clock, async active-high reset
//   frame_h/w, row_gap  frame geometry and inter-row idle, sampled on start
//   start, hold         frame request, read pause
//   rd_en, rd_addr      memory read strobe and raster address
//   rd_data             memory data, one cycle after rd_en
//   frame_start         first pixel of the frame on dout
//   dout_vld, dout      output pixel stream
//   busy, done          frame in progress, end-of-frame pulse
module frame_tx #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int DIN_WIDTH   = 8,
    parameter int CH_NUM      = 4,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(FRAME_H_MAX):0]         frame_h,
    input  logic [$clog2(FRAME_W_MAX):0]         frame_w,
    input  logic [GAP_WIDTH-1:0]                 row_gap,
    input  logic                                 start,
    input  logic                                 hold,
    output logic                                 rd_en,
    output logic [$clog2(FRAME_H_MAX*FRAME_W_MAX)-1:0] rd_addr,
    input  logic [CH_NUM*DIN_WIDTH-1:0]          rd_data,
    output logic                                 frame_start,
    output logic                                 dout_vld,
    output logic [CH_NUM-1:0][DIN_WIDTH-1:0]     dout,
    output logic                                 busy,
    output logic                                 done
);

    localparam int HW = $clog2(FRAME_H_MAX) + 1;
    localparam int WW = $clog2(FRAME_W_MAX) + 1;
    localparam int AW = $clog2(FRAME_H_MAX * FRAME_W_MAX);

    localparam logic [HW-1:0]        ONE_H = 1;
    localparam logic [WW-1:0]        ONE_W = 1;
    localparam logic [AW-1:0]        ONE_A = 1;
    localparam logic [GAP_WIDTH-1:0] ONE_G = 1;

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        GAP,
        DRAIN
    } state_t;

    state_t                        state_q, state_d;
    logic [HW-1:0]                 h_q, h_d;
    logic [WW-1:0]                 w_q, w_d;
    logic [GAP_WIDTH-1:0]          gap_q, gap_d;
    logic [HW-1:0]                 row_q, row_d;
    logic [WW-1:0]                 col_q, col_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [GAP_WIDTH-1:0]          gcnt_q, gcnt_d;
    // Stage 1: a read was issued last cycle, rd_data is valid now.
    logic                          v1_q, v1_d;
    logic                          f1_q, f1_d;
    logic                          l1_q, l1_d;
    // Stage 2: registered output pixel and strobes.
    logic                          vld_q, vld_d;
    logic                          fs_q, fs_d;
    logic                          done_q, done_d;
    logic [CH_NUM*DIN_WIDTH-1:0]   dout_q, dout_d;
    logic                          rd_en_c;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        w_d     = w_q;
        gap_d   = gap_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        gcnt_d  = gcnt_q;
        rd_en_c = 1'b0;
        v1_d    = 1'b0;
        f1_d    = 1'b0;
        l1_d    = 1'b0;
        vld_d   = v1_q;
        fs_d    = f1_q;
        done_d  = l1_q;
        dout_d  = v1_q ? rd_data : dout_q;

        unique case (state_q)
            IDLE: begin
                if (start && frame_h != '0 && frame_w != '0) begin
                    h_d     = frame_h;
                    w_d     = frame_w;
                    gap_d   = row_gap;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                    state_d = ROW;
                end
            end
            ROW: begin
                if (!hold) begin
                    rd_en_c = 1'b1;
                    v1_d    = 1'b1;
                    f1_d    = (addr_q == '0);
                    addr_d  = addr_q + ONE_A;
                    if (col_q == w_q - ONE_W) begin
                        if (row_q == h_q - ONE_H) begin
                            l1_d    = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + ONE_H;
                            col_d = '0;
                            if (gap_q != '0) begin
                                gcnt_d  = gap_q - ONE_G;
                                state_d = GAP;
                            end
                        end
                    end else begin
                        col_d = col_q + ONE_W;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    state_d = ROW;
                end else begin
                    gcnt_d = gcnt_q - ONE_G;
                end
            end
            DRAIN: begin
                // done_q marks the last pixel's output cycle
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            w_q     <= '0;
            gap_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            gcnt_q  <= '0;
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            l1_q    <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            w_q     <= w_d;
            gap_q   <= gap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            gcnt_q  <= gcnt_d;
            v1_q    <= v1_d;
            f1_q    <= f1_d;
            l1_q    <= l1_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign rd_en       = rd_en_c;
    assign rd_addr     = addr_q;
    assign frame_start = fs_q;
    assign dout_vld    = vld_q;
    assign dout        = dout_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule
